// File: rtl/logic_gate_unit.sv
`timescale 1ns/1ps
// logic_gate_unit
//   Two-stage streaming reducer. NUM_IN operands of WIDTH bits are combined
//   bitwise by a per-beat function (OR/AND/XOR/NOR/NAND/XNOR/pass/invert of
//   operand 0). Beats flagged with in_acc are folded into a sticky OR
//   accumulator, and a saturating counter tracks how many were folded.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake
//   in_data              NUM_IN operands, operand k at [k*WIDTH +: WIDTH]
//   in_op                function select, captured with the beat
//   in_acc               fold this beat into the accumulator
//   acc_clear            synchronous accumulator/count clear
//   out_valid/out_ready  output handshake
//   out_data             result (or accumulated value for acc beats)
//   out_any              reduction OR of out_data
//   out_count            folded-beat count including this beat (0 for non-acc)
module logic_gate_unit #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [2:0]              in_op,
  input  logic                    in_acc,
  input  logic                    acc_clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_any,
  output logic [CNT_W-1:0]        out_count
);

  localparam logic [2:0] OP_OR   = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_PASS = 3'd6;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // in_ready is held low until the first edge after reset release
  logic rdy_en_q;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_res_q,   s1_res_d;
  logic             s1_acc_q,   s1_acc_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] red_or, red_and, red_xor, func_res;
  logic             s2_adv, s1_load, accept;
  logic [WIDTH-1:0] acc_base, acc_sum;
  logic [CNT_W-1:0] cnt_base, cnt_inc;

  always_comb begin
    red_or   = '0;
    red_and  = '1;
    red_xor  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      red_or  = red_or  | in_data[k*WIDTH +: WIDTH];
      red_and = red_and & in_data[k*WIDTH +: WIDTH];
      red_xor = red_xor ^ in_data[k*WIDTH +: WIDTH];
    end
    func_res = '0;
    case (in_op)
      OP_OR:   func_res = red_or;
      OP_AND:  func_res = red_and;
      OP_XOR:  func_res = red_xor;
      OP_NOR:  func_res = ~red_or;
      OP_NAND: func_res = ~red_and;
      OP_XNOR: func_res = ~red_xor;
      OP_PASS: func_res = in_data[WIDTH-1:0];
      default: func_res = ~in_data[WIDTH-1:0];
    endcase
  end

  // Ready chain: in_ready depends combinationally on out_ready only.
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_load  = !s1_valid_q || s2_adv;
    in_ready = rdy_en_q && s1_load;
    accept   = in_valid && in_ready;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_res_d   = s1_res_q;
    s1_acc_d   = s1_acc_q;
    if (s1_load) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_res_d = func_res;
        s1_acc_d = in_acc;
      end
    end
  end

  // A clear on the same edge as an acc beat loading S2 wipes the old value
  // first, so the beat starts a fresh accumulation.
  always_comb begin
    acc_base    = acc_clear ? '0 : acc_q;
    cnt_base    = acc_clear ? '0 : cnt_q;
    acc_sum     = acc_base | s1_res_q;
    cnt_inc     = (cnt_base == '1) ? cnt_base : cnt_base + CNT_ONE;
    s2_valid_d  = s2_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    acc_d       = acc_base;
    cnt_d       = cnt_base;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        if (s1_acc_q) begin
          acc_d       = acc_sum;
          cnt_d       = cnt_inc;
          out_data_d  = acc_sum;
          out_count_d = cnt_inc;
        end else begin
          out_data_d  = s1_res_q;
          out_count_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_res_q    <= '0;
      s1_acc_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      rdy_en_q    <= 1'b1;
      s1_valid_q  <= s1_valid_d;
      s1_res_q    <= s1_res_d;
      s1_acc_q    <= s1_acc_d;
      s2_valid_q  <= s2_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_any   = |out_data_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
`timescale 1ns/1ps
module tb_logic_gate_unit;
  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_acc = 1'b0, acc_clear = 1'b0, out_ready = 1'b1;
  logic [N*W-1:0] in_data = '0;
  logic [2:0] in_op = '0;

  logic in_ready, out_valid, out_any;
  logic [W-1:0] out_data;
  logic [7:0] out_count;
  logic s_in_ready, s_out_valid, s_out_any;
  logic [W-1:0] s_out_data;
  logic [1:0] s_out_count;

  always #5 clk = ~clk;

  logic_gate_unit #(.WIDTH(W), .NUM_IN(N), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_op(in_op), .in_acc(in_acc), .acc_clear(acc_clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_any(out_any), .out_count(out_count));

  logic_gate_unit #(.WIDTH(W), .NUM_IN(N), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_op(in_op), .in_acc(in_acc), .acc_clear(acc_clear),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_any(s_out_any), .out_count(s_out_count));

  typedef struct { logic [7:0] data; int count; } exp_t;
  typedef struct { logic [2:0] op; logic [31:0] data; logic [7:0] exp_data; logic exp_any; } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[8];

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;
  bit auto_mode = 0;
  int inflight = 0;
  int m_cnt = 0;
  logic [7:0] m_acc = '0;
  bit prev_stall = 0;
  logic [7:0] prev_data = '0;
  logic prev_any = 1'b0;
  logic [7:0] prev_count = '0;

  logic [7:0] sat_vals[5];
  logic [7:0] sat_main[5];
  int sat_cnt[5];

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: per bit, count how many operands hold a 1 and apply the rule.
  function automatic logic [7:0] ref_fn(input logic [31:0] d, input logic [2:0] op);
    logic [7:0] r;
    int n;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      n = 0;
      for (int k = 0; k < 4; k++) if (d[k*8+b]) n++;
      case (op)
        3'd0: r[b] = (n != 0);
        3'd1: r[b] = (n == 4);
        3'd2: r[b] = (n % 2 == 1);
        3'd3: r[b] = (n == 0);
        3'd4: r[b] = (n != 4);
        3'd5: r[b] = (n % 2 == 0);
        3'd6: r[b] = d[b];
        default: r[b] = !d[b];
      endcase
    end
    return r;
  endfunction

  task automatic push_exp(input logic [7:0] d, input int c);
    exp_t e;
    e.data = d;
    e.count = c;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk_eq("in_ready", {31'd0, in_ready}, (inflight == 2 && !out_ready) ? 32'd0 : 32'd1);
      if (prev_stall) begin
        chk_eq("stall_valid", {31'd0, out_valid}, 32'd1);
        chk_eq("stall_data", {24'd0, out_data}, {24'd0, prev_data});
        chk_eq("stall_any", {31'd0, out_any}, {31'd0, prev_any});
        chk_eq("stall_count", {24'd0, out_count}, {24'd0, prev_count});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk_eq("spurious_out", {31'd0, out_valid}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk_eq("out_data", {24'd0, out_data}, {24'd0, mon_e.data});
          chk_eq("out_any", {31'd0, out_any}, {31'd0, |mon_e.data});
          chk_eq("out_count", {24'd0, out_count}, mon_e.count);
        end
        inflight--;
      end
      if (in_valid && in_ready) begin
        inflight++;
        if (auto_mode) begin
          if (in_acc) begin
            m_acc = m_acc | ref_fn(in_data, in_op);
            m_cnt++;
            push_exp(m_acc, (m_cnt > 255) ? 255 : m_cnt);
          end else begin
            push_exp(ref_fn(in_data, in_op), 0);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_any   = out_any;
      prev_count = out_count;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic send(input logic [31:0] d, input logic [2:0] op, input logic acc);
    int t;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_op = op; in_acc = acc;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 50);
    if (!in_ready) chk_eq("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
  endtask

  task automatic drain();
    int t;
    t = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || inflight != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk_eq("drain_left", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    mon_en = 0;
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; acc_clear = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete(); inflight = 0; m_acc = '0; m_cnt = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1;
  endtask

  initial begin
    int lat, sent, cyc, acc_first, ov_first, ov_len, stale, t;
    vecs[0] = '{3'd0, 32'hFF55330F, 8'hFF, 1'b1};
    vecs[1] = '{3'd1, 32'hFF55330F, 8'h01, 1'b1};
    vecs[2] = '{3'd2, 32'hFF55330F, 8'h96, 1'b1};
    vecs[3] = '{3'd3, 32'hFF55330F, 8'h00, 1'b0};
    vecs[4] = '{3'd4, 32'hFF55330F, 8'hFE, 1'b1};
    vecs[5] = '{3'd5, 32'hFF55330F, 8'h69, 1'b1};
    vecs[6] = '{3'd6, 32'hFF55330F, 8'h0F, 1'b1};
    vecs[7] = '{3'd7, 32'hFF55330F, 8'hF0, 1'b1};
    sat_vals = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    sat_main = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};
    sat_cnt  = '{1, 2, 3, 3, 3};

    // reset state
    #12;
    chk_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk_eq("rst_out_data", {24'd0, out_data}, 32'd0);
    chk_eq("rst_out_any", {31'd0, out_any}, 32'd0);
    chk_eq("rst_out_count", {24'd0, out_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_eq("in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk_eq("in_ready_after_edge", {31'd0, in_ready}, 32'd1);
    mon_en = 1;

    // function sweep with latency
    for (int i = 0; i < 8; i++) begin
      push_exp(vecs[i].exp_data, 0);
      send(vecs[i].data, vecs[i].op, 1'b0);
      wait_out(lat);
      chk_eq("sweep_latency", lat, 32'd2);
      chk_eq("sweep_any", {31'd0, out_any}, {31'd0, vecs[i].exp_any});
    end
    drain();

    // accumulation
    push_exp(8'h01, 1); push_exp(8'h05, 2); push_exp(8'h85, 3);
    send(32'h01, 3'd6, 1'b1);
    send(32'h04, 3'd6, 1'b1);
    send(32'h80, 3'd6, 1'b1);
    drain();
    acc_clear = 1'b1;
    @(posedge clk); #1;
    acc_clear = 1'b0;
    push_exp(8'h10, 1);
    send(32'h10, 3'd6, 1'b1);
    drain();

    // clear colliding with an acc beat entering the output stage
    acc_clear = 1'b1;
    @(posedge clk); #1;
    acc_clear = 1'b0;
    push_exp(8'h85, 1);
    send(32'h85, 3'd6, 1'b1);
    drain();
    push_exp(8'h02, 1);
    send(32'h02, 3'd6, 1'b1);
    acc_clear = 1'b1;
    @(posedge clk); #1;
    acc_clear = 1'b0;
    drain();
    push_exp(8'h42, 2);
    send(32'h40, 3'd6, 1'b1);
    drain();

    // clear while a result is held stalled in the output stage
    out_ready = 1'b0;
    push_exp(8'h4A, 3);
    send(32'h08, 3'd6, 1'b1);
    @(posedge clk); #1;
    acc_clear = 1'b1;
    @(posedge clk); #1;
    acc_clear = 1'b0;
    drain();
    push_exp(8'h01, 1);
    send(32'h01, 3'd6, 1'b1);
    drain();

    // backpressure with in_valid held high
    do_reset();
    auto_mode = 1;
    sent = 0; cyc = 0;
    in_data = $urandom; in_op = 3'($urandom_range(0, 7)); in_acc = 1'b0;
    while (sent < 6 && cyc < 200) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      out_ready = (cyc % 4 == 0 || cyc % 4 == 3);
      @(negedge clk);
      if (in_ready) begin
        sent++;
        @(posedge clk); #1;
        in_data = $urandom; in_op = 3'($urandom_range(0, 7));
        out_ready = (cyc % 4 == 0);
        cyc++;
        @(negedge clk);
        if (in_ready && sent < 6) sent++;
        else if (in_ready) in_valid = 1'b1;
      end
      cyc++;
    end
    chk_eq("bp_sent", sent, 32'd6);
    drain();

    // throughput
    out_ready = 1'b1;
    sent = 0; acc_first = -1; ov_first = -1; ov_len = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      in_valid = (sent < 16);
      in_data = $urandom; in_op = 3'($urandom_range(0, 7)); in_acc = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (acc_first < 0) acc_first = k;
        sent++;
      end
      if (out_valid) begin
        if (ov_first < 0) ov_first = k;
        if (k == ov_first + ov_len) ov_len++;
      end
    end
    chk_eq("tput_sent", sent, 32'd16);
    chk_eq("tput_start", ov_first - acc_first, 32'd2);
    chk_eq("tput_run", ov_len, 32'd16);
    drain();

    // randomized traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data = $urandom; in_op = 3'($urandom_range(0, 7)); in_acc = 1'($urandom_range(0, 1));
    end
    drain();
    auto_mode = 0;

    // counter saturation (CNT_W=2 instance alongside the default one)
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push_exp(sat_main[i], i + 1);
      send({24'd0, sat_vals[i]}, 3'd6, 1'b1);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!s_out_valid && t < 20);
      chk_eq("sat_count", {30'd0, s_out_count}, sat_cnt[i]);
      chk_eq("sat_data", {24'd0, s_out_data}, {24'd0, sat_main[i]});
    end
    drain();

    // reset with two beats in flight
    mon_en = 0;
    out_ready = 1'b0;
    send(32'h20, 3'd6, 1'b1);
    send(32'h40, 3'd6, 1'b1);
    #2;
    chk_eq("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    chk_eq("pre_rst_full", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk_eq("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk_eq("midrst_data", {24'd0, out_data}, 32'd0);
    chk_eq("midrst_count", {24'd0, out_count}, 32'd0);
    repeat (3) @(negedge clk);
    exp_q.delete(); inflight = 0; m_acc = '0; m_cnt = 0;
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk_eq("stale_after_rst", stale, 32'd0);
    mon_en = 1;
    push_exp(8'h20, 1);
    send(32'h20, 3'd6, 1'b1);
    drain();

    chk_eq("final_queue", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
